// File: rtl/text_line_buffer.sv
// Single-line character buffer with cursor editing and a registered display read port.
// Full-line advance scrolls left when TEXT_LINE_BUFFER_SCROLL_EN is defined, else it is refused.
module text_line_buffer #(
  parameter int DATA_WIDTH = 7,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 30,
  parameter int CHAR_MAX   = 69
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_up,
  input  logic                  key_down,
  input  logic                  back,
  input  logic                  enter,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] cursor,
  output logic [DATA_WIDTH-1:0] cur_char,
  output logic                  full,
  output logic                  overflow,
  output logic [7:0]            scroll_cnt
);

  localparam logic [ADDR_WIDTH-1:0] LAST   = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] CMAX   = DATA_WIDTH'(CHAR_MAX);

  logic [DATA_WIDTH-1:0] ram [DEPTH];
  logic [ADDR_WIDTH-1:0] cursor_nxt;

  logic do_back, do_enter, do_up, do_down;
  logic advance, at_end, char_at_max, char_zero;

  // One command per cycle: clear > back > enter > key_up > key_down.
  assign do_back  = !clear && back;
  assign do_enter = !clear && !back && enter;
  assign do_up    = !clear && !back && !enter && key_up;
  assign do_down  = !clear && !back && !enter && !key_up && key_down;

  assign cur_char    = ram[cursor];
  assign char_at_max = (cur_char >= CMAX);
  assign char_zero   = (cur_char == '0);
  assign at_end      = (cursor == LAST);
  assign full        = at_end;
  assign cursor_nxt  = cursor + 1'b1;

  // key_up on a maxed cell turns into an advance instead of wrapping.
  assign advance = do_enter || (do_up && char_at_max);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
    end else if (do_back) begin
      ram[cursor] <= '0;
    end else if (advance) begin
      if (!at_end) begin
        ram[cursor_nxt] <= '0;
      end else begin
`ifdef TEXT_LINE_BUFFER_SCROLL_EN
        for (int i = 0; i < DEPTH - 1; i++) ram[i] <= ram[i+1];
        ram[DEPTH-1] <= '0;
`endif
      end
    end else if (do_up) begin
      ram[cursor] <= cur_char + 1'b1;
    end else if (do_down && !char_zero) begin
      ram[cursor] <= cur_char - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cursor <= '0;
    end else if (clear) begin
      cursor <= '0;
    end else if (do_back) begin
      if (cursor != '0) cursor <= cursor - 1'b1;
    end else if (advance && !at_end) begin
      cursor <= cursor_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else begin
      overflow <= !clear && advance && at_end;
    end
  end

  // Read sees the array before this cycle's edit lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if ({1'b0, rd_addr} < DEPTH_W) begin
      rd_data <= ram[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

`ifdef TEXT_LINE_BUFFER_SCROLL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scroll_cnt <= '0;
    end else if (clear) begin
      scroll_cnt <= '0;
    end else if (advance && at_end && scroll_cnt != 8'hff) begin
      scroll_cnt <= scroll_cnt + 8'd1;
    end
  end
`else
  assign scroll_cnt = 8'd0;
`endif

endmodule

// File: doc/text_line_buffer.md
# text_line_buffer

Parametrised single-line character buffer with cursor editing for the keyboard/text-display path. Key events raise or lower the character code at the cursor, commit it and advance, or erase it and step back. The buffer keeps its whole contents in a register array and exposes them through a registered read port for the display scanner. When the line is full, new input either scrolls the line left or is refused, chosen at compile time.

## Interface
Parameters:
- DATA_WIDTH, 7, character code width
- ADDR_WIDTH, 5, cursor/read address width
- DEPTH, 30, number of character cells; 2 ≤ DEPTH ≤ 2**ADDR_WIDTH
- CHAR_MAX, 69, highest legal character code; CHAR_MAX < 2**DATA_WIDTH

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- key_up  in  1  one-cycle pulse: increment code at cursor
- key_down  in  1  one-cycle pulse: decrement code at cursor
- back  in  1  one-cycle pulse: erase cell at cursor, step left
- enter  in  1  one-cycle pulse: commit cell, advance cursor
- clear  in  1  one-cycle pulse: empty the whole line
- rd_addr  in  ADDR_WIDTH  display read address
- rd_data  out  DATA_WIDTH  registered cell contents at rd_addr
- cursor  out  ADDR_WIDTH  current cursor cell index; also the count of committed cells
- cur_char  out  DATA_WIDTH  code in the cursor cell, driven combinationally from the array
- full  out  1  level: cursor == DEPTH-1
- overflow  out  1  one-cycle pulse: advance attempted while full
- scroll_cnt  out  8  cells scrolled out since reset/clear; saturates at 255

## Operation
- State: cell array ram[0..DEPTH-1], cursor c. Cells below c are committed. Cell c is under edit.
- Exactly one command executes per cycle. Priority: clear > back > enter > key_up > key_down. Lower-priority pulses in the same cycle are dropped.
- clear: all cells set to 0, c set to 0, scroll_cnt set to 0.
- back: ram[c] set to 0. If c > 0, c decrements. At c == 0 only the cell clears.
- enter: performs an ADVANCE.
- key_up: if ram[c] < CHAR_MAX, ram[c] increments by 1. Otherwise ADVANCE; the code never exceeds CHAR_MAX.
- key_down: if ram[c] > 0, ram[c] decrements by 1. At 0 it saturates and nothing else changes.
- ADVANCE when c < DEPTH-1: c increments and ram[c+1] is set to 0. Cell c keeps its value.
- ADVANCE when c == DEPTH-1: behaviour is set by the Configuration section.
- Read port: rd_data takes ram[rd_addr] at the clock edge, using pre-edit contents (read-before-write). If rd_addr ≥ DEPTH, rd_data is 0.
- Arithmetic: increments and decrements are DATA_WIDTH-bit with no wrap. The cursor never leaves 0..DEPTH-1.

## Timing
- Reset values: all cells 0, cursor 0, rd_data 0, overflow 0, scroll_cnt 0. Consequently full = 0 (with DEPTH ≥ 2) and cur_char = 0.
- Reset asserted mid-command aborts the command; all state returns to reset values immediately.
- Command latency: one cycle. cursor, cur_char and full reflect a command after the edge that samples it.
- rd_data latency: one cycle from rd_addr.
- overflow is high for exactly the cycle after the edge that sampled the refused or scrolling advance.
- Held inputs act once per cycle. Edge detection is upstream.

## Configuration
- TEXT_LINE_BUFFER_SCROLL_EN defined: an ADVANCE at c == DEPTH-1 does the following in one cycle:
  - ram[i] ← ram[i+1] for i = 0..DEPTH-2
  - ram[DEPTH-1] ← 0
  - c stays at DEPTH-1
  - scroll_cnt increments, saturating at 255
  - overflow pulses
- TEXT_LINE_BUFFER_SCROLL_EN undefined: an ADVANCE at c == DEPTH-1 is refused:
  - contents and cursor are unchanged; ram[c] stays at its current value, including CHAR_MAX
  - overflow pulses
  - scroll_cnt stays 0 and does not need to be implemented as a register

## Test plan
- Reset, then 3 key_up then enter → ram[0]=3, cursor=1, cur_char=0; read rd_addr=0 → rd_data=3 one cycle later.
- 70 key_up pulses from an empty cell (CHAR_MAX=69) → 69 increments, 70th advances: ram[0]=69, cursor=1, cur_char=0.
- key_down at 0 → no change. back at cursor=2 with ram[2]=5 → ram[2]=0, cursor=1. back at cursor=0 → only the cell clears.
- Same-cycle back+enter+key_up at cursor=4 → only back executes (cursor=3). Then clear+key_up → all cells 0, cursor=0.
- Fill 30 cells with codes 1..30 using enter between them (cursor reaches 29), then enter:
  - SCROLL_EN: ram[0]=2, ram[28]=30, ram[29]=0, cursor=29, scroll_cnt=1, overflow pulses once.
  - Without SCROLL_EN: contents unchanged, overflow pulses, full stays 1.
- Assert rst while cursor=10 and full line edits are in progress → all outputs return to reset values immediately, independent of clk.
